sram_controller: RTL and testbench
==================================

// Module: sram_controller
// PURPOSE
//  Initiator side of the 32-bit asynchronous-style SRAM interface (WE_N/ADDR/DQ) used by the
//  data memory. Sits in the MEM stage of the ARM pipeline: accepts one read or write request,
//  drives the SRAM for a fixed number of wait cycles and stalls the pipeline via READY until
//  the access completes. Returns read data to the MEM/WB register.
// PARAMETERS
//  WAIT_CYCLES  5      cycles SRAM_ADDR/SRAM_DQ/SRAM_WE_N are held per access (>=1; covers SRAM read delay)
//  BASE_ADDR    1024   byte address mapped to SRAM word 0
// PORTS
//  CLK         in     1   system clock, all state updates on posedge
//  RST         in     1   synchronous, active-high reset
//  MEM_R_EN    in     1   read request from EXE/MEM register, held stable while READY=0
//  MEM_W_EN    in     1   write request, held stable while READY=0
//  ADDR        in     32  byte address (word aligned; ADDR[1:0] ignored)
//  WR_DATA     in     32  write data
//  READ_DATA   out    32  registered read data, valid in the cycle READY returns high
//  READY       out    1   0 = freeze pipeline; 1 = no access pending or access complete
//  SRAM_WE_N   out    1   active-low write enable to SRAM
//  SRAM_ADDR   out    17  SRAM word address
//  SRAM_DQ     inout  32  SRAM data bus; driven only during WRITE, else high-Z
// BEHAVIOUR
//  - Reset (sync, RST=1 at posedge): state IDLE, SRAM_WE_N=1, SRAM_ADDR=0, READ_DATA=0,
//    wait counter=0, SRAM_DQ high-Z. Reset mid-access aborts it: next cycle WE_N=1, DQ released.
//  - States: IDLE, READ, WRITE, DONE.
//    IDLE : req = MEM_R_EN|MEM_W_EN. If MEM_W_EN -> WRITE, else if MEM_R_EN -> READ; capture
//           SRAM_ADDR = (ADDR - BASE_ADDR)[18:2] and WR_DATA; clear counter. Else stay.
//    READ : SRAM_WE_N=1, DQ high-Z; counter++; at counter==WAIT_CYCLES-1 latch SRAM_DQ into
//           READ_DATA and go DONE.
//    WRITE: SRAM_WE_N=0, DQ driven with captured data; counter++; at WAIT_CYCLES-1 -> DONE.
//    DONE : SRAM_WE_N=1, DQ high-Z; -> IDLE unconditionally (request seen again in IDLE = new access).
//  - SRAM_WE_N is registered (low exactly for the WAIT_CYCLES cycles of WRITE).
//  - READY (combinational) = (IDLE & ~req) | DONE. Latency: request in cycle 0 -> READY=0 for
//    cycles 0..WAIT_CYCLES, READY=1 in cycle WAIT_CYCLES+1 (DONE).
//  - Simultaneous MEM_R_EN & MEM_W_EN: write wins, no read performed, READ_DATA unchanged.
//  - Address arithmetic modulo 2^32; bits above [18:2] discarded (wrap within 128K words).
//  - READ_DATA holds its value until the next completed read.
//  - Request inputs changing while READY=0 are ignored (captured values used).
// STRUCTURE
//  - Shared package sram_ctrl_pkg: state enum (IDLE/READ/WRITE/DONE), SRAM_ADDR_W=17,
//    SRAM_DATA_W=32, default BASE_ADDR.
//  - One sub-module: sram_wait_counter (clear, enable, terminal-count flag at WAIT_CYCLES-1).
//  - Tri-state driver for SRAM_DQ kept in the top module.
// TESTING (bench instantiates SRAM model with 30-unit read delay, CLK period 20)
//  1. Reset: RST=1 two cycles -> SRAM_WE_N=1, SRAM_ADDR=0, READ_DATA=0, SRAM_DQ=Z, READY=1.
//  2. Write ADDR=1024, WR_DATA=32'hDEADBEEF -> SRAM_ADDR=0, WE_N=0 for 5 cycles, READY=0 for
//     6 cycles then 1 for one cycle; SRAM word 0 = DEADBEEF.
//  3. Read ADDR=1024 after test 2 -> READY high in cycle 6, READ_DATA=32'hDEADBEEF; WE_N stays 1.
//  4. Back-to-back: write 1028<-32'h12345678 then read 1028 without idle -> SRAM_ADDR=1, DONE
//     then IDLE restart, read returns 12345678.
//  5. MEM_R_EN=MEM_W_EN=1, ADDR=1032, data 32'hA5A5A5A5 -> write performed, READ_DATA unchanged.
//  6. RST asserted in 3rd WRITE cycle -> next cycle WE_N=1, DQ=Z, READY=1, state IDLE.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// The state encoding is kept as plain constants so older tools can consume it unchanged.
`timescale 1ns/1ps
package sram_ctrl_pkg;

  localparam int          SRAM_ADDR_W       = 17;
  localparam int          SRAM_DATA_W       = 32;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/sram_wait_counter.sv
// Access-duration counter: cleared while idle, counts each access cycle and flags
// the last one. It wraps to zero on the last cycle so any WAIT_CYCLES fits the width.
`timescale 1ns/1ps
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int                CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_srst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_terminal ? '0 : r_count + 1'b1;
    end
  end

  assign o_terminal = (r_count == LAST);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage SRAM initiator: one read or write per request, held for WAIT_CYCLES,
// pipeline frozen through READY until the DONE cycle hands back the result.
`timescale 1ns/1ps
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            ADDR,
  input  logic [SRAM_DATA_W-1:0] WR_DATA,
  output logic [SRAM_DATA_W-1:0] READ_DATA,
  output logic                   READY,
  output logic                   SRAM_WE_N,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_we_n;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [SRAM_DATA_W-1:0] r_wr_data;
  logic [SRAM_DATA_W-1:0] r_read_data;

  logic        w_req;
  logic        w_terminal;
  logic [31:0] w_offset;
  logic        w_unused_offset;

  assign w_req    = MEM_R_EN | MEM_W_EN;
  assign w_offset = ADDR - BASE_ADDR;
  // Byte-lane bits and everything above the 128K-word window are dropped, so addresses wrap.
  assign w_unused_offset = ^{w_offset[31:SRAM_ADDR_W+2], w_offset[1:0]};

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .i_clk      (CLK),
    .i_srst     (RST),
    .i_clear    (r_state == ST_IDLE),
    .i_enable   ((r_state == ST_READ) || (r_state == ST_WRITE)),
    .o_terminal (w_terminal)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (MEM_W_EN)      w_state_next = ST_WRITE;
        else if (MEM_R_EN) w_state_next = ST_READ;
      end
      ST_READ:  if (w_terminal) w_state_next = ST_DONE;
      ST_WRITE: if (w_terminal) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_we_n      <= 1'b1;
      r_sram_addr <= '0;
      r_wr_data   <= '0;
      r_read_data <= '0;
    end else begin
      r_state <= w_state_next;
      // Registered from the next state so WE_N is low for exactly the WRITE cycles.
      r_we_n  <= (w_state_next != ST_WRITE);
      if ((r_state == ST_IDLE) && w_req) begin
        r_sram_addr <= w_offset[SRAM_ADDR_W+1:2];
        r_wr_data   <= WR_DATA;
      end
      if ((r_state == ST_READ) && w_terminal) begin
        r_read_data <= SRAM_DQ;
      end
    end
  end

  assign SRAM_DQ   = (r_state == ST_WRITE) ? r_wr_data : {SRAM_DATA_W{1'bz}};
  assign SRAM_WE_N = r_we_n;
  assign SRAM_ADDR = r_sram_addr;
  assign READ_DATA = r_read_data;
  assign READY     = ((r_state == ST_IDLE) && !w_req) || (r_state == ST_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: an SRAM model with a 30-unit read delay on the bus,
// plus a word-level reference memory that predicts latency, addresses and data.
`timescale 1ns/1ps
module tb_sram_controller;

  localparam int          WAIT     = 5;
  localparam logic [31:0] BASE     = 32'd1024;
  localparam int          RD_DELAY = 30;
  localparam int          WORDS    = 131072;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  wire  [31:0] read_data;
  wire         ready;
  wire         sram_we_n;
  wire  [16:0] sram_addr;
  wire  [31:0] sram_dq;

  int checks = 0;
  int errors = 0;

  // SRAM device model
  logic [31:0]     sram_mem [0:WORDS-1];
  logic [31:0]     sram_out = 32'hBAD0_BAD0;
  longint unsigned t_addr = 0;

  // Reference model: word-addressed memory plus the last completed read
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ref_read_data = '0;

  always #10 clk = ~clk;

  sram_controller #(
    .WAIT_CYCLES (WAIT),
    .BASE_ADDR   (BASE)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .MEM_R_EN  (mem_r_en),
    .MEM_W_EN  (mem_w_en),
    .ADDR      (addr),
    .WR_DATA   (wr_data),
    .READ_DATA (read_data),
    .READY     (ready),
    .SRAM_WE_N (sram_we_n),
    .SRAM_ADDR (sram_addr),
    .SRAM_DQ   (sram_dq)
  );

  assign sram_dq = sram_we_n ? sram_out : 32'hzzzz_zzzz;

  always @(sram_addr) t_addr = $time;

  always @(negedge clk) begin
    if ($time - t_addr >= RD_DELAY) sram_out <= sram_mem[sram_addr];
    else                            sram_out <= 32'hBAD0_BAD0;
  end

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
  end

  function automatic int unsigned exp_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off / 4) % WORDS;
  endfunction

  function automatic logic [31:0] ref_lookup(input int unsigned w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 32'h0;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One access starting in the current cycle; returns one cycle after the DONE edge.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit scramble, input string tag);
    int          low_cnt;
    int          we_cnt;
    int          exp_low;
    bit          got;
    int unsigned word;
    logic [16:0] exp_sa;
    low_cnt = 0;
    we_cnt  = 0;
    got     = 0;
    word    = exp_word(a);
    exp_sa  = word[16:0];
    exp_low = (r || w) ? WAIT + 1 : 0;
    mem_r_en = r;
    mem_w_en = w;
    addr     = a;
    wr_data  = d;
    while (!got && low_cnt < 4 * WAIT + 10) begin
      @(negedge clk); #1;
      if (ready) begin
        got = 1;
      end else begin
        if (low_cnt > 0) begin
          checks++;
          if (sram_addr !== exp_sa) begin
            errors++;
            $display("FAIL %s sram_addr_hold: got %h expected %h", tag, sram_addr, exp_sa);
          end
          if (scramble) begin
            addr     = $urandom;
            wr_data  = $urandom;
            mem_r_en = 1'($urandom_range(0, 1));
            mem_w_en = 1'($urandom_range(0, 1));
          end
        end
        if (!sram_we_n) begin
          we_cnt++;
          checks++;
          if (sram_dq !== d) begin
            errors++;
            $display("FAIL %s dq_drive: got %h expected %h", tag, sram_dq, d);
          end
        end
        low_cnt++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s ready_timeout: ready still 0 after %0d cycles, expected 1 after %0d", tag, low_cnt, exp_low);
    end
    if (w)           ref_mem[word] = d;
    else if (r)      ref_read_data = ref_lookup(word);
    checks++;
    if (low_cnt != exp_low) begin
      errors++;
      $display("FAIL %s ready_low_cycles: got %0d expected %0d", tag, low_cnt, exp_low);
    end
    checks++;
    if (we_cnt != (w ? WAIT : 0)) begin
      errors++;
      $display("FAIL %s we_n_low_cycles: got %0d expected %0d", tag, we_cnt, w ? WAIT : 0);
    end
    checks++;
    if (sram_we_n !== 1'b1) begin
      errors++;
      $display("FAIL %s we_n_done: got %b expected 1", tag, sram_we_n);
    end
    checks++;
    if (read_data !== ref_read_data) begin
      errors++;
      $display("FAIL %s read_data: got %h expected %h", tag, read_data, ref_read_data);
    end
    if (r || w) begin
      checks++;
      if (sram_addr !== exp_sa) begin
        errors++;
        $display("FAIL %s sram_addr: got %h expected %h", tag, sram_addr, exp_sa);
      end
    end
    if (w) begin
      checks++;
      if (sram_mem[exp_sa] !== d) begin
        errors++;
        $display("FAIL %s sram_word: got %h expected %h", tag, sram_mem[exp_sa], d);
      end
    end
    $display("txn %s r=%0d w=%0d addr=%h data=%h word=%0d ready_low=%0d we_low=%0d read_data=%h",
             tag, r, w, a, d, word, low_cnt, we_cnt, read_data);
    @(posedge clk); #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", sram_we_n); end
    checks++;
    if (sram_addr !== 17'h0) begin errors++; $display("FAIL reset_sram_addr: got %h expected 0", sram_addr); end
    checks++;
    if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h expected 0", read_data); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++;
    if (sram_dq !== sram_out) begin errors++; $display("FAIL reset_dq_released: bus %h expected SRAM drive %h", sram_dq, sram_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("txn reset we_n=%b sram_addr=%h read_data=%h ready=%b", sram_we_n, sram_addr, read_data, ready);
    idle(1);
  endtask

  task automatic test_write_read();
    access(1'b0, 1'b1, BASE, 32'hDEAD_BEEF, 1'b0, "write_base");
    idle(1);
    access(1'b1, 1'b0, BASE, 32'h0, 1'b0, "read_base");
    idle(1);
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b1, BASE + 32'd4, 32'h1234_5678, 1'b0, "b2b_write");
    access(1'b1, 1'b0, BASE + 32'd4, 32'h0, 1'b0, "b2b_read");
    idle(1);
  endtask

  task automatic test_both_enables();
    access(1'b1, 1'b1, BASE + 32'd8, 32'hA5A5_A5A5, 1'b0, "both_en");
    idle(1);
    access(1'b1, 1'b0, BASE + 32'd8, 32'h0, 1'b0, "both_en_rb");
    idle(1);
  endtask

  task automatic test_reset_abort();
    logic [31:0] a;
    a = BASE + 32'd160;
    mem_w_en = 1'b1;
    addr     = a;
    wr_data  = 32'hCAFE_F00D;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (sram_we_n !== 1'b0) begin errors++; $display("FAIL abort_we_n_before: got %b expected 0", sram_we_n); end
    rst      = 1'b1;
    mem_w_en = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (sram_we_n !== 1'b1) begin errors++; $display("FAIL abort_we_n: got %b expected 1", sram_we_n); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", ready); end
    checks++;
    if (sram_addr !== 17'h0) begin errors++; $display("FAIL abort_sram_addr: got %h expected 0", sram_addr); end
    checks++;
    if (sram_dq !== sram_out) begin errors++; $display("FAIL abort_dq_released: bus %h expected SRAM drive %h", sram_dq, sram_out); end
    $display("txn reset_abort addr=%h we_n=%b ready=%b dq=%h", a, sram_we_n, ready, sram_dq);
    @(posedge clk); #1;
    rst = 1'b0;
    // The SRAM already saw WE_N low with the data on the bus before the abort.
    ref_mem[exp_word(a)] = 32'hCAFE_F00D;
    ref_read_data        = 32'h0;
    idle(1);
    access(1'b1, 1'b0, a, 32'h0, 1'b0, "abort_rb");
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        r;
    logic        w;
    bit          scr;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom & 32'hFFFF_FFFC;
      else                           a = BASE + 32'(4 * $urandom_range(0, 15));
      r   = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      scr = ($urandom_range(0, 3) == 0);
      access(r, w, a, $urandom, scr, scr ? "rand_scr" : "rand");
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) sram_mem[i] = 32'h0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_both_enables();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
